regfile_np_sb: RTL

- Parametrised general-purpose register file for the 8-bit core. Successor to the fixed 16x8, single-write, two-read bank.
- Two write ports: WA for the ALU writeback, WB for the load/IO writeback. Read-port count is configurable.
- Optional write-through bypass and optional hardwired-zero register 0.
- Per-register scoreboard (busy bits) lets the decoder stall on registers with an outstanding load.

---
 rtl/regfile_np_sb.sv | 70 +++++++
 1 files changed

// File: rtl/regfile_np_sb.sv
// regfile_np_sb: dual-write, multi-read register file with write-through bypass,
// optional hardwired-zero r0 and a load scoreboard with sticky misuse flags.
module regfile_np_sb #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int NUM_RD  = 2,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     lock_en,
    input  logic [ADDR_W-1:0]        lock_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic                     any_busy,
    output logic                     err_dbl_lock,
    output logic                     err_stray_wb
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, set_m, clr_m;
    logic              wa_ok, wb_ok, lock_ok;

    // with a hardwired r0, every access to address 0 is dropped before it reaches state
    assign wa_ok   = wa_en && !(R0_ZERO != 0 && wa_addr == '0);
    assign wb_ok   = wb_en && !(R0_ZERO != 0 && wb_addr == '0);
    assign lock_ok = lock_en && !(R0_ZERO != 0 && lock_addr == '0);

    always_comb begin
        set_m = lock_ok ? DEPTH'(1) << lock_addr : '0;
        clr_m = wb_ok ? DEPTH'(1) << wb_addr : '0;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy         <= '0;
            err_dbl_lock <= 1'b0;
            err_stray_wb <= 1'b0;
        end else begin
            if (wb_ok) mem[wb_addr] <= wb_data;
            if (wa_ok) mem[wa_addr] <= wa_data;
            busy         <= (busy & ~clr_m) | set_m;
            err_dbl_lock <= err_dbl_lock | (lock_ok & busy[lock_addr]);
            err_stray_wb <= err_stray_wb | (wb_ok & ~busy[wb_addr]);
        end
    end

    assign any_busy = |busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              zero, hit_a, hit_b;
        assign a     = rd_addr[k*ADDR_W +: ADDR_W];
        assign zero  = R0_ZERO != 0 && a == '0;
        assign hit_a = BYPASS != 0 && wa_ok && wa_addr == a;
        assign hit_b = BYPASS != 0 && wb_ok && wb_addr == a;
        assign rd_data[k*DATA_W +: DATA_W] = zero ? '0 : hit_a ? wa_data : hit_b ? wb_data : mem[a];
        // a completing load clears busy in the same cycle; a new lock only shows after the edge
        assign rd_busy[k] = !zero && !hit_b && busy[a];
    end
endmodule
